// File: rtl/io_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : io_arb
//  Description : Two-master arbiter for a shared single-cycle IO port.
//                Round-robin tie-break, per-master lock with idle timeout,
//                and registered read-response return.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_arb #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 10,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,        // active-low, async assert, sync release
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic                m0_lock,
  input  logic [AWIDTH-1:0]   m0_addr,
  input  logic [DWIDTH-1:0]   m0_wdata,
  input  logic [DWIDTH/8-1:0] m0_wbe,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DWIDTH-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic                m1_lock,
  input  logic [AWIDTH-1:0]   m1_addr,
  input  logic [DWIDTH-1:0]   m1_wdata,
  input  logic [DWIDTH/8-1:0] m1_wbe,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DWIDTH-1:0]   m1_rdata,
  output logic                io_en,
  output logic [AWIDTH-1:0]   io_addr,
  output logic [DWIDTH-1:0]   io_din,
  output logic [DWIDTH/8-1:0] io_wbe,
  input  logic [DWIDTH-1:0]   io_dout
);

  localparam logic [7:0] c_timeout = 8'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;      // 1 = master 1 won most recently
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          w_cnt_inc;
  logic                m0_rvalid_q, m0_rvalid_d;
  logic                m1_rvalid_q, m1_rvalid_d;
  logic [DWIDTH-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DWIDTH-1:0]   m1_rdata_q, m1_rdata_d;
  logic                w_g0, w_g1;

  // Grant decode: a grant is only ever raised for a requesting master, so
  // grant alone marks an accepted transfer. Nothing is granted in reset.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (rst) begin
      case (state_q)
        OPEN: begin
          if (m0_req && m1_req) begin
            w_g0 = last_q;
            w_g1 = ~last_q;
          end else begin
            w_g0 = m0_req;
            w_g1 = m1_req;
          end
        end
        LOCK0:   w_g0 = m0_req;
        LOCK1:   w_g1 = m1_req;
        default: ;
      endcase
    end
  end

  // Shared IO port mux; all fields forced to zero when idle.
  always_comb begin
    io_en   = w_g0 | w_g1;
    io_addr = '0;
    io_din  = '0;
    io_wbe  = '0;
    if (w_g0) begin
      io_addr = m0_addr;
      io_din  = m0_wdata;
      io_wbe  = m0_we ? m0_wbe : '0;
    end else if (w_g1) begin
      io_addr = m1_addr;
      io_din  = m1_wdata;
      io_wbe  = m1_we ? m1_wbe : '0;
    end
  end

  assign w_cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Ownership FSM, last-grant and lock idle counter next-state logic.
  // The release fires on the edge where the counter would reach the timeout,
  // so the arbiter is open in the very next cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (w_g0)      last_d = 1'b0;
    else if (w_g1) last_d = 1'b1;
    case (state_q)
      OPEN: begin
        cnt_d = 8'd0;
        if (w_g0 && m0_lock)      state_d = LOCK0;
        else if (w_g1 && m1_lock) state_d = LOCK1;
      end
      LOCK0: begin
        if (w_g0) begin
          cnt_d = 8'd0;
          if (!m0_lock) state_d = OPEN;
        end else if (w_cnt_inc >= c_timeout) begin
          state_d = OPEN;
          cnt_d   = 8'd0;
          last_d  = 1'b0;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      LOCK1: begin
        if (w_g1) begin
          cnt_d = 8'd0;
          if (!m1_lock) state_d = OPEN;
        end else if (w_cnt_inc >= c_timeout) begin
          state_d = OPEN;
          cnt_d   = 8'd0;
          last_d  = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      default: begin
        state_d = OPEN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Read response capture: io_dout is sampled at the end of the read cycle.
  always_comb begin
    m0_rvalid_d = w_g0 & ~m0_we;
    m1_rvalid_d = w_g1 & ~m1_we;
    m0_rdata_d  = m0_rvalid_d ? io_dout : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? io_dout : m1_rdata_q;
  end

  // State registers; reset drops any lock and any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= OPEN;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt    = w_g0;
  assign m1_gnt    = w_g1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
`default_nettype wire

// File: doc/io_arb.md
IO_ARB -- requirements
Module: io_arb

Interface
REQ-001 The module SHALL provide parameter DWIDTH, default 32, data width of every data port.
REQ-002 The module SHALL provide parameter AWIDTH, default 10, width of every address port.
REQ-003 The module SHALL provide parameter LOCK_TIMEOUT, default 16, idle cycles after which a held lock is forcibly released (legal range 1..255).
REQ-004 The module SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL provide port rst, input, 1, asynchronous active-low reset; assertion is immediate and deassertion is synchronous to clk.
REQ-006 The module SHALL provide ports m0_req / m1_req, input, 1 each, access request from master 0 (core) / master 1 (debug/DMA).
REQ-007 The module SHALL provide ports mX_we, input, 1; mX_lock, input, 1; mX_addr, input, AWIDTH; mX_wdata, input, DWIDTH; mX_wbe, input, DWIDTH/8; these are request qualifiers for X = 0, 1.
REQ-008 The module SHALL provide ports mX_gnt, output, 1, which is high in the cycle in which master X's request is accepted.
REQ-009 The module SHALL provide ports mX_rvalid, output, 1, and mX_rdata, output, DWIDTH, which carry the read response to master X.
REQ-010 The module SHALL provide ports io_en, output, 1; io_addr, output, AWIDTH; io_din, output, DWIDTH; io_wbe, output, DWIDTH/8; these drive the shared IO controller port.
REQ-011 The module SHALL provide port io_dout, input, DWIDTH, the IO controller read data, valid combinationally in the same cycle as io_en.

Function
REQ-012 Ownership FSM: states OPEN, LOCK0 and LOCK1.
REQ-013 In OPEN with exactly one mX_req high, the block SHALL assert mX_gnt combinationally in the same cycle.
REQ-014 In OPEN with both requests high, grant goes to the master not recorded in the 1-bit last-grant register.
REQ-015 The last-grant register SHALL update to the winner on every accepted transfer.
REQ-016 In LOCKX, only master X may be granted; the other master's mX_gnt SHALL stay 0 even while it requests.
REQ-017 Accepted transfer (mX_req & mX_gnt): io_en=1, io_addr=mX_addr, io_din=mX_wdata, io_wbe = mX_we ? mX_wbe : 0, all in the same cycle; each transfer occupies exactly one cycle.
REQ-018 When no transfer is accepted, io_en, io_wbe, io_addr and io_din SHALL all be 0.
REQ-019 Read accepted in cycle N (mX_we=0): io_dout SHALL be captured at the edge ending cycle N, and mX_rvalid=1 with mX_rdata SHALL be presented in cycle N+1 for exactly one cycle.
REQ-020 Back-to-back reads SHALL sustain one read per cycle.
REQ-021 mX_rdata SHALL hold its last value when mX_rvalid=0.
REQ-022 Writes SHALL produce no rvalid.
REQ-023 Lock entry: an accepted transfer with mX_lock=1 SHALL move the FSM to LOCKX.
REQ-024 Lock exit: an accepted transfer from owner X with mX_lock=0 SHALL move the FSM to OPEN after that transfer.
REQ-025 Lock timeout counter: reset to 0 on each accepted owner transfer; increment each LOCKX cycle in which mX_req=0; saturate at 255.
REQ-026 When the counter reaches LOCK_TIMEOUT, the FSM SHALL return to OPEN in the next cycle, the counter SHALL clear, and last-grant SHALL be set to X, so the other master wins the next simultaneous request.
REQ-027 A request with mX_lock=1 accepted while already in LOCKX by owner X SHALL keep the FSM in LOCKX and SHALL clear the counter.
REQ-028 mX_lock SHALL be ignored on cycles in which master X is not granted.
REQ-029 Request signals are level-held by masters until granted; the block SHALL NOT buffer an ungranted request.

Reset
REQ-030 While rst=0: FSM=OPEN, last-grant=1 (so master 0 wins the first tie), timeout counter=0, mX_rvalid=0, mX_rdata=0, and io_en, io_wbe, io_addr and io_din all 0.
REQ-031 Reset asserted mid-lock or with a read response pending SHALL discard the lock and the pending rvalid; no rvalid SHALL appear after deassertion.
REQ-032 mX_gnt SHALL be 0 while rst=0, regardless of requests.

Verification
REQ-033 Tie after reset: both req, reads, addr0=0x008, addr1=0x010, io_dout=0xA5 -> cycle 0 m0_gnt=1, io_addr=0x008; cycle 1 m0_rvalid=1, m0_rdata=0xA5, m1_gnt=1, io_addr=0x010.
REQ-034 Write: m1 write addr=0x008, wdata=0x5, wbe=0xF -> io_en=1, io_wbe=0xF, io_din=0x5 that cycle; no m1_rvalid.
REQ-035 Lock hold: m0 locked write, then m1 requests for 5 cycles while m0 is idle -> m1_gnt=0 throughout; an m0 transfer with lock=0 releases; m1 is granted the following cycle.
REQ-036 Timeout: LOCK_TIMEOUT=4, m0 locks then stays idle, m1 requests continuously -> m1_gnt rises exactly 5 cycles after the lock transfer.
REQ-037 Reset mid-read: read accepted, rst pulled low before the next edge -> m0_rvalid stays 0; after release FSM=OPEN and the first tie goes to m0.
